// File: rtl/round_controller_if.sv
// Signal bundle between the round sequencer and the rest of the snake game:
// frame timing, key/collision/food inputs and the flow/score outputs.
interface round_controller_if;
  logic        frame_clk;
  logic [15:0] keycode;
  logic        hit;
  logic        eat1;
  logic        eat2;
  logic        snake_rst;
  logic        play_en;
  logic [2:0]  state;
  logic [1:0]  countdown;
  logic [7:0]  score1;
  logic [7:0]  score2;
  logic [1:0]  lives;
  logic        game_over;

  modport master (
    output frame_clk, keycode, hit, eat1, eat2,
    input  snake_rst, play_en, state, countdown, score1, score2, lives, game_over
  );

  modport slave (
    input  frame_clk, keycode, hit, eat1, eat2,
    output snake_rst, play_en, state, countdown, score1, score2, lives, game_over
  );
endinterface

// File: rtl/round_controller.sv
// Round sequencer for the two-snake game: countdown, play, pause, hit freeze
// and game over, with per-snake scores and a shared life counter.
module round_controller #(
  parameter int          COUNT_FRAMES  = 60,
  parameter int          COUNT_DIGITS  = 3,
  parameter int          FREEZE_FRAMES = 90,
  parameter int          LIVES         = 3,
  parameter int          SCORE_MAX     = 99,
  parameter logic [7:0]  START_KEY     = 8'h28,
  parameter logic [7:0]  PAUSE_KEY     = 8'h13
) (
  input  logic               Clk,
  input  logic               Reset_n,
  round_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_HIT   = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  localparam logic [6:0] CNT_LAST   = 7'(COUNT_FRAMES - 1);
  localparam logic [6:0] FRZ_LAST   = 7'(FREEZE_FRAMES - 1);
  localparam logic [1:0] DIGITS     = 2'(COUNT_DIGITS);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [7:0] SCORE_TOP  = 8'(SCORE_MAX);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= SCORE_TOP) ? SCORE_TOP : v + 8'd1;
  endfunction

  logic frame_p0, frame_p1, frame_p2;
  logic start_p0, start_p1, pause_p0, pause_p1;
  logic eat1_p0, eat1_p1, eat2_p0, eat2_p1;
  logic hit_p0;

  logic start_lvl, pause_lvl;
  logic tick, start_press, pause_press, eat1_edge, eat2_edge;

  state_t     state_p1, state_n;
  logic [6:0] frame_cnt_p1, frame_cnt_n;
  logic [1:0] countdown_p1, countdown_n;
  logic [7:0] score1_p1, score1_n, score2_p1, score2_n;
  logic [1:0] lives_p1, lives_n;
  logic       snake_rst_p1, play_en_p1, game_over_p1;

  assign start_lvl = (bus.keycode[7:0] == START_KEY) | (bus.keycode[15:8] == START_KEY);
  assign pause_lvl = (bus.keycode[7:0] == PAUSE_KEY) | (bus.keycode[15:8] == PAUSE_KEY);

  // Stage 0: frame_clk synchroniser plus level capture for edge detection
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_p0 <= 1'b0;
      frame_p1 <= 1'b0;
      frame_p2 <= 1'b0;
      start_p0 <= 1'b0;
      start_p1 <= 1'b0;
      pause_p0 <= 1'b0;
      pause_p1 <= 1'b0;
      eat1_p0  <= 1'b0;
      eat1_p1  <= 1'b0;
      eat2_p0  <= 1'b0;
      eat2_p1  <= 1'b0;
      hit_p0   <= 1'b0;
    end else begin
      frame_p0 <= bus.frame_clk;
      frame_p1 <= frame_p0;
      frame_p2 <= frame_p1;
      start_p0 <= start_lvl;
      start_p1 <= start_p0;
      pause_p0 <= pause_lvl;
      pause_p1 <= pause_p0;
      eat1_p0  <= bus.eat1;
      eat1_p1  <= eat1_p0;
      eat2_p0  <= bus.eat2;
      eat2_p1  <= eat2_p0;
      hit_p0   <= bus.hit;
    end
  end

  assign tick        = frame_p1 & ~frame_p2;
  assign start_press = start_p0 & ~start_p1;
  assign pause_press = pause_p0 & ~pause_p1;
  assign eat1_edge   = eat1_p0 & ~eat1_p1;
  assign eat2_edge   = eat2_p0 & ~eat2_p1;

  always_comb begin
    state_n     = state_p1;
    frame_cnt_n = frame_cnt_p1;
    countdown_n = countdown_p1;
    score1_n    = score1_p1;
    score2_n    = score2_p1;
    lives_n     = lives_p1;
    unique case (state_p1)
      S_IDLE, S_OVER: begin
        if (start_press) begin
          score1_n    = 8'd0;
          score2_n    = 8'd0;
          lives_n     = LIVES_INIT;
          countdown_n = DIGITS;
          frame_cnt_n = 7'd0;
          state_n     = S_COUNT;
        end
      end
      S_COUNT: begin
        if (tick) begin
          if (frame_cnt_p1 == CNT_LAST) begin
            frame_cnt_n = 7'd0;
            countdown_n = countdown_p1 - 2'd1;
            if (countdown_p1 == 2'd1) state_n = S_PLAY;
          end else begin
            frame_cnt_n = frame_cnt_p1 + 7'd1;
          end
        end
      end
      S_PLAY: begin
        // Collision outranks pause, which outranks food in the same cycle.
        if (hit_p0) begin
          if (lives_p1 <= 2'd1) begin
            lives_n = 2'd0;
            state_n = S_OVER;
          end else begin
            lives_n     = lives_p1 - 2'd1;
            frame_cnt_n = 7'd0;
            state_n     = S_HIT;
          end
        end else if (pause_press) begin
          state_n = S_PAUSE;
        end else begin
          if (eat1_edge) score1_n = sat_inc(score1_p1);
          if (eat2_edge) score2_n = sat_inc(score2_p1);
        end
      end
      S_PAUSE: begin
        if (pause_press) state_n = S_PLAY;
      end
      S_HIT: begin
        if (tick) begin
          if (frame_cnt_p1 == FRZ_LAST) begin
            frame_cnt_n = 7'd0;
            countdown_n = DIGITS;
            state_n     = S_COUNT;
          end else begin
            frame_cnt_n = frame_cnt_p1 + 7'd1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Stage 1: round state, counters and outputs decoded from the next state
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_p1     <= S_IDLE;
      frame_cnt_p1 <= 7'd0;
      countdown_p1 <= 2'd0;
      score1_p1    <= 8'd0;
      score2_p1    <= 8'd0;
      lives_p1     <= LIVES_INIT;
      snake_rst_p1 <= 1'b1;
      play_en_p1   <= 1'b0;
      game_over_p1 <= 1'b0;
    end else begin
      state_p1     <= state_n;
      frame_cnt_p1 <= frame_cnt_n;
      countdown_p1 <= countdown_n;
      score1_p1    <= score1_n;
      score2_p1    <= score2_n;
      lives_p1     <= lives_n;
      snake_rst_p1 <= (state_n == S_IDLE) | (state_n == S_COUNT) | (state_n == S_OVER);
      play_en_p1   <= (state_n == S_PLAY);
      game_over_p1 <= (state_n == S_OVER);
    end
  end

  assign bus.state     = state_p1;
  assign bus.countdown = countdown_p1;
  assign bus.score1    = score1_p1;
  assign bus.score2    = score2_p1;
  assign bus.lives     = lives_p1;
  assign bus.snake_rst = snake_rst_p1;
  assign bus.play_en   = play_en_p1;
  assign bus.game_over = game_over_p1;

endmodule
